// File: rtl/serial_add_ctrl.sv
// Bit-serial add sequencer: feeds one external full-adder cell LSB-first, one bit
// per clock, through a registered carry loop, and returns Sum/Cout/Ovf over a handshake.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             FA_A,
  output logic             FA_B,
  output logic             FA_Cin,
  input  logic             FA_Sum,
  input  logic             FA_Cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic [CW-1:0]    cnt;
  logic             carry_q, ovf_q;
  logic             accept, last, running;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Handshake outputs are masked by rst so nothing is offered during reset.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        accept   = in_valid;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        last = (cnt == LAST);
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = !rst;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign running = (state == RUN);

  // Cell inputs come straight from registers, so the external cell never closes a comb loop.
  assign FA_A   = running & a_sh[0];
  assign FA_B   = running & b_sh[0];
  assign FA_Cin = running & carry_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_sh    <= A;
      b_sh    <= B;
      carry_q <= Cin;
      cnt     <= '0;
      sum_sh  <= '0;
    end else if (running) begin
      sum_sh  <= {FA_Sum, sum_sh[WIDTH-1:1]};
      carry_q <= FA_Cout;
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      cnt     <= cnt + CW'(1);
      // carry_q here is the carry into the MSB
      if (last) ovf_q <= carry_q ^ FA_Cout;
    end
  end

  assign Sum  = sum_sh;
  assign Cout = carry_q;
  assign Ovf  = ovf_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: an 8-bit and a 4-bit instance, each driving a modelled
// full-adder cell, checked every cycle against an arithmetic reference model.
module tb_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0] ivld = '0, ordy = '0, cin = '0;
  logic [7:0] a [2];
  logic [7:0] b [2];
  wire  [1:0] irdy, ovld, fa_a, fa_b, fa_c, fs, fco, cout, ovf;
  wire  [7:0] sum8;
  wire  [3:0] sum4;

  // The external full-adder cells
  assign fs  = fa_a ^ fa_b ^ fa_c;
  assign fco = (fa_a & fa_b) | (fa_c & (fa_a ^ fa_b));

  serial_add_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(ivld[0]), .in_ready(irdy[0]),
    .A(a[0]), .B(b[0]), .Cin(cin[0]),
    .FA_A(fa_a[0]), .FA_B(fa_b[0]), .FA_Cin(fa_c[0]), .FA_Sum(fs[0]), .FA_Cout(fco[0]),
    .out_valid(ovld[0]), .out_ready(ordy[0]), .Sum(sum8), .Cout(cout[0]), .Ovf(ovf[0]));

  serial_add_ctrl #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(ivld[1]), .in_ready(irdy[1]),
    .A(a[1][3:0]), .B(b[1][3:0]), .Cin(cin[1]),
    .FA_A(fa_a[1]), .FA_B(fa_b[1]), .FA_Cin(fa_c[1]), .FA_Sum(fs[1]), .FA_Cout(fco[1]),
    .out_valid(ovld[1]), .out_ready(ordy[1]), .Sum(sum4), .Cout(cout[1]), .Ovf(ovf[1]));

  function automatic int wd(int k);
    return (k != 0) ? 4 : 8;
  endfunction

  // Reference model: since = -1 when idle, 0..W-1 during bit-serial work, W while holding result.
  int   since [2] = '{-1, -1};
  bit   clean [2] = '{1'b0, 1'b0};
  int   ea [2], eb [2], ec [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        since[k] = -1;
        clean[k] = 1'b1;
      end else if (since[k] < 0) begin
        if (ivld[k]) begin
          ea[k]    = int'(a[k]) & ((1 << wd(k)) - 1);
          eb[k]    = int'(b[k]) & ((1 << wd(k)) - 1);
          ec[k]    = int'(cin[k]);
          since[k] = 0;
          clean[k] = 1'b0;
        end
      end else if (since[k] < wd(k)) begin
        since[k]++;
      end else if (ordy[k]) begin
        since[k] = -1;
      end
    end
  end

  int vectors = 0, miscompares = 0;

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s (W=%0d) at %0t: got %0h expected %0h", nm, wd(k), $time, act, exp);
    end
  endtask

  // Literal expectations for directed 8-bit operations
  logic       lit_en = 1'b0;
  logic [7:0] lit_sum = '0;
  logic       lit_co = 1'b0, lit_ov = 1'b0;

  always @(negedge clk) begin
    int w, s, tot, esum, msb, i, msk, ecar;
    logic [7:0] asum;
    bit run, done, eov;
    for (int k = 0; k < 2; k++) begin
      w    = wd(k);
      s    = since[k];
      run  = (s >= 0) && (s < w);
      done = (s == w);
      asum = (k != 0) ? {4'b0, sum4} : sum8;
      chk("in_ready", k, 32'(irdy[k]), 32'(!rst && s < 0));
      chk("out_valid", k, 32'(ovld[k]), 32'(!rst && done));
      if (run) begin
        i    = s;
        msk  = (1 << i) - 1;
        ecar = (((ea[k] & msk) + (eb[k] & msk) + ec[k]) >> i) & 1;
        chk("FA_A", k, 32'(fa_a[k]), 32'((ea[k] >> i) & 1));
        chk("FA_B", k, 32'(fa_b[k]), 32'((eb[k] >> i) & 1));
        chk("FA_Cin", k, 32'(fa_c[k]), 32'(ecar));
      end else begin
        chk("FA_idle", k, {29'b0, fa_a[k], fa_b[k], fa_c[k]}, 32'd0);
      end
      if (!rst && done) begin
        tot  = ea[k] + eb[k] + ec[k];
        esum = tot & ((1 << w) - 1);
        msb  = w - 1;
        eov  = (((ea[k] >> msb) & 1) == ((eb[k] >> msb) & 1)) &&
               (((esum >> msb) & 1) != ((ea[k] >> msb) & 1));
        chk("Sum", k, 32'(asum), 32'(esum));
        chk("Cout", k, 32'(cout[k]), 32'((tot >> w) & 1));
        chk("Ovf", k, 32'(ovf[k]), 32'(eov));
        if (k == 0 && lit_en) begin
          chk("lit_Sum", k, 32'(sum8), 32'(lit_sum));
          chk("lit_Cout", k, 32'(cout[0]), 32'(lit_co));
          chk("lit_Ovf", k, 32'(ovf[0]), 32'(lit_ov));
        end
      end else if (clean[k]) begin
        chk("reset_regs", k, {22'b0, asum, cout[k], ovf[k]}, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(logic [7:0] s, logic co, logic ov);
    lit_en  = 1'b1;
    lit_sum = s;
    lit_co  = co;
    lit_ov  = ov;
  endtask

  // One operation; stall<0 means random out_ready, else out_ready low for that many DONE cycles.
  task automatic op(int k, logic [7:0] av, logic [7:0] bv, logic c, int stall, bit keep);
    int held, guard;
    held  = 0;
    guard = 0;
    ivld[k] = 1'b1;
    a[k] = av;
    b[k] = bv;
    cin[k] = c;
    tick();
    if (!keep) ivld[k] = 1'b0;
    a[k] = 8'($urandom);
    b[k] = 8'($urandom);
    cin[k] = 1'($urandom);
    while (since[k] >= 0 && guard < 300) begin
      if (since[k] == wd(k)) begin
        ordy[k] = (stall < 0) ? 1'($urandom) : (held >= stall);
        held++;
      end else begin
        ordy[k] = 1'($urandom);
      end
      tick();
      guard++;
    end
    if (!keep) ivld[k] = 1'b0;
    ordy[k] = 1'b0;
    lit_en = 1'b0;
  endtask

  initial begin
    a[0] = '0; a[1] = '0; b[0] = '0; b[1] = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    lit(8'h8D, 1'b0, 1'b1); op(0, 8'h5A, 8'h33, 1'b0, -1, 1'b0);
    lit(8'h00, 1'b1, 1'b0); op(0, 8'hFF, 8'h01, 1'b0, -1, 1'b0);
    lit(8'h01, 1'b1, 1'b1); op(0, 8'h80, 8'h80, 1'b1, -1, 1'b0);
    lit(8'hB4, 1'b0, 1'b0); op(0, 8'hA5, 8'h0F, 1'b0, 0, 1'b0);

    // Backpressure with in_valid held high through RUN and DONE
    lit(8'h8D, 1'b0, 1'b1); op(0, 8'h5A, 8'h33, 1'b0, 5, 1'b1);
    op(0, 8'h7F, 8'h01, 1'b0, 0, 1'b0);

    // Reset on the third RUN cycle discards the operation
    ivld[0] = 1'b1; a[0] = 8'h5A; b[0] = 8'h33; cin[0] = 1'b0;
    tick();
    ivld[0] = 1'b0; ordy[0] = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (12) tick();
    ordy[0] = 1'b0;
    lit(8'h02, 1'b0, 1'b0); op(0, 8'h01, 8'h01, 1'b0, -1, 1'b0);

    // Random 8-bit traffic with occasional stalls and idle gaps
    for (int n = 0; n < 150; n++) begin
      op(0, 8'($urandom), 8'($urandom), 1'($urandom),
         ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 6)) : -1, 1'b0);
      repeat ($urandom_range(0, 2)) tick();
    end

    // Exhaustive 4-bit sweep with random out_ready stalls
    for (int av = 0; av < 16; av++)
      for (int bv = 0; bv < 16; bv++)
        for (int c = 0; c < 2; c++)
          op(1, 8'(av), 8'(bv), 1'(c), -1, 1'b0);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
